// File: rtl/cpu_pkg.sv
// Shared types and constants for the 16-bit multicycle datapath.
package cpu_pkg;

  localparam int unsigned DATA_W = 16;
  localparam logic [DATA_W-1:0] PC_RESET = 16'h0000;

  // Watchdog counter width; holds timeouts up to 255 cycles.
  localparam int unsigned WD_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_watchdog.sv
// Saturating cycle counter that flags when an outstanding fetch has waited too long.
// expired is registered and rises on the edge where the count reaches TIMEOUT-1,
// so the controller acts on the edge where the count reaches TIMEOUT.
module fetch_watchdog
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic CLK,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [WD_W-1:0] LIMIT    = WD_W'(TIMEOUT);
  localparam logic [WD_W-1:0] LIMIT_M1 = WD_W'(TIMEOUT - 1);
  localparam logic            EXP_CLR  = (TIMEOUT == 1);

  logic [WD_W-1:0] count;
  logic [WD_W-1:0] count_inc;

  // Increment that holds at the limit instead of wrapping.
  always_comb begin
    count_inc = count;
    if (count < LIMIT) begin
      count_inc = count + WD_W'(1);
    end
  end

  // Counter and expiry flag; clear takes priority over enable.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      count   <= '0;
      expired <= 1'b0;
    end else if (clr) begin
      count   <= '0;
      expired <= EXP_CLR;
    end else if (en) begin
      count   <= count_inc;
      expired <= (count_inc >= LIMIT_M1);
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues req/ack instruction reads, handles redirects and timeouts.
module instruction_fetch
  import cpu_pkg::fetch_state_e, cpu_pkg::ST_IDLE, cpu_pkg::ST_WAIT, cpu_pkg::ST_FAULT;
#(
  parameter int unsigned           DATA_W   = cpu_pkg::DATA_W,
  parameter logic [DATA_W-1:0]     PC_RESET = DATA_W'(cpu_pkg::PC_RESET),
  parameter int unsigned           PC_STEP  = 1,
  parameter int unsigned           TIMEOUT  = 15
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              fetch,
  input  logic              pcLoad,
  input  logic [DATA_W-1:0] pcTarget,
  input  logic              clearFault,
  output logic [DATA_W-1:0] memAddr,
  output logic              memReq,
  input  logic              memAck,
  input  logic [DATA_W-1:0] memData,
  output logic [DATA_W-1:0] instruction,
  output logic [DATA_W-1:0] PC,
  output logic [DATA_W-1:0] pcNext,
  output logic              instrValid,
  output logic              busy,
  output logic              fault
);

  localparam logic [DATA_W-1:0] STEP = DATA_W'(PC_STEP);

  fetch_state_e      state, state_d;
  logic [DATA_W-1:0] mem_addr_d, instruction_d, pc_d, pc_next_d;
  logic              mem_req_d, instr_valid_d;
  logic              pend_valid, pend_valid_d;
  logic [DATA_W-1:0] pend_target, pend_target_d;
  logic              wd_expired;
  logic              wd_clr_c, wd_en_c;

  // Watchdog runs only while a request is outstanding and no ack arrives.
  assign wd_clr_c = (state != ST_WAIT);
  assign wd_en_c  = (state == ST_WAIT) && !memAck;

  fetch_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .CLK     (CLK),
    .reset   (reset),
    .clr     (wd_clr_c),
    .en      (wd_en_c),
    .expired (wd_expired)
  );

  // State and datapath registers.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state       <= ST_IDLE;
      memAddr     <= '0;
      memReq      <= 1'b0;
      instruction <= '0;
      PC          <= '0;
      pcNext      <= PC_RESET;
      instrValid  <= 1'b0;
      busy        <= 1'b0;
      fault       <= 1'b0;
      pend_valid  <= 1'b0;
      pend_target <= '0;
    end else begin
      state       <= state_d;
      memAddr     <= mem_addr_d;
      memReq      <= mem_req_d;
      instruction <= instruction_d;
      PC          <= pc_d;
      pcNext      <= pc_next_d;
      instrValid  <= instr_valid_d;
      busy        <= (state_d == ST_WAIT);
      fault       <= (state_d == ST_FAULT);
      pend_valid  <= pend_valid_d;
      pend_target <= pend_target_d;
    end
  end

  // Next-state and next-value logic.
  always_comb begin
    state_d       = state;
    mem_addr_d    = memAddr;
    mem_req_d     = memReq;
    instruction_d = instruction;
    pc_d          = PC;
    pc_next_d     = pcNext;
    instr_valid_d = 1'b0;
    pend_valid_d  = pend_valid;
    pend_target_d = pend_target;

    unique case (state)
      ST_IDLE: begin
        if (fetch) begin
          // A simultaneous redirect supplies the address for this fetch.
          if (pcLoad) begin
            mem_addr_d = pcTarget;
            pc_next_d  = pcTarget;
          end else begin
            mem_addr_d = pcNext;
          end
          mem_req_d    = 1'b1;
          pend_valid_d = 1'b0;
          state_d      = ST_WAIT;
        end else if (pcLoad) begin
          pc_next_d = pcTarget;
        end
      end

      ST_WAIT: begin
        if (memAck) begin
          if (pcLoad || pend_valid) begin
            // Redirected while in flight: the returned word is stale.
            pc_next_d = pcLoad ? pcTarget : pend_target;
          end else begin
            instruction_d = memData;
            pc_d          = memAddr;
            pc_next_d     = memAddr + STEP;
            instr_valid_d = 1'b1;
          end
          pend_valid_d = 1'b0;
          mem_req_d    = 1'b0;
          state_d      = ST_IDLE;
        end else if (wd_expired) begin
          if (pcLoad) begin
            pc_next_d = pcTarget;
          end else if (pend_valid) begin
            pc_next_d = pend_target;
          end
          pend_valid_d = 1'b0;
          mem_req_d    = 1'b0;
          state_d      = ST_FAULT;
        end else if (pcLoad) begin
          pend_valid_d  = 1'b1;
          pend_target_d = pcTarget;
        end
      end

      ST_FAULT: begin
        if (pcLoad) begin
          pc_next_d = pcTarget;
        end
        if (clearFault) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        mem_req_d    = 1'b0;
        pend_valid_d = 1'b0;
        state_d      = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with hand-computed expectations.
module tb_instruction_fetch;

  logic        CLK = 1'b0;
  logic        reset;
  logic        fetch;
  logic        pcLoad;
  logic [15:0] pcTarget;
  logic        clearFault;
  logic [15:0] memAddr;
  logic        memReq;
  logic        memAck;
  logic [15:0] memData;
  logic [15:0] instruction;
  logic [15:0] PC;
  logic [15:0] pcNext;
  logic        instrValid;
  logic        busy;
  logic        fault;

  int checks = 0;
  int errors = 0;

  instruction_fetch #(
    .DATA_W   (16),
    .PC_RESET (16'h0000),
    .PC_STEP  (1),
    .TIMEOUT  (15)
  ) dut (
    .CLK         (CLK),
    .reset       (reset),
    .fetch       (fetch),
    .pcLoad      (pcLoad),
    .pcTarget    (pcTarget),
    .clearFault  (clearFault),
    .memAddr     (memAddr),
    .memReq      (memReq),
    .memAck      (memAck),
    .memData     (memData),
    .instruction (instruction),
    .PC          (PC),
    .pcNext      (pcNext),
    .instrValid  (instrValid),
    .busy        (busy),
    .fault       (fault)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; fetch = 1'b0; pcLoad = 1'b0; pcTarget = '0;
    clearFault = 1'b0; memAck = 1'b0; memData = '0;
    tick(); tick();
    checks++; if ({memReq, instrValid, busy, fault} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {memReq, instrValid, busy, fault}); end
    checks++; if ({memAddr, instruction, PC, pcNext} !== 64'h0) begin errors++; $display("FAIL reset_regs: got %h expected 0", {memAddr, instruction, PC, pcNext}); end
    reset = 1'b1;
    tick();
    checks++; if ({memReq, busy, pcNext} !== 18'h0) begin errors++; $display("FAIL reset_release: got %h expected 0", {memReq, busy, pcNext}); end
  endtask

  task automatic test_basic_fetch();
    fetch = 1'b1; tick(); fetch = 1'b0;
    checks++; if ({memReq, busy, memAddr} !== {2'b11, 16'h0000}) begin errors++; $display("FAIL basic_req: got %h expected %h", {memReq, busy, memAddr}, {2'b11, 16'h0000}); end
    memAck = 1'b1; memData = 16'h1234; tick(); memAck = 1'b0;
    checks++; if (instrValid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", instrValid); end
    checks++; if ({instruction, PC, pcNext} !== {16'h1234, 16'h0000, 16'h0001}) begin errors++; $display("FAIL basic_data: got %h expected %h", {instruction, PC, pcNext}, {16'h1234, 16'h0000, 16'h0001}); end
    checks++; if ({memReq, busy} !== 2'b00) begin errors++; $display("FAIL basic_done: got %b expected 00", {memReq, busy}); end
    tick();
    checks++; if (instrValid !== 1'b0) begin errors++; $display("FAIL basic_pulse: got %b expected 0", instrValid); end
  endtask

  task automatic test_delayed_ack();
    fetch = 1'b1; tick();
    for (int i = 0; i < 5; i++) begin
      checks++; if ({memReq, busy, instrValid, fault, memAddr} !== {4'b1100, 16'h0001}) begin errors++; $display("FAIL delay_hold_%0d: got %h expected %h", i, {memReq, busy, instrValid, fault, memAddr}, {4'b1100, 16'h0001}); end
      if (i == 4) begin fetch = 1'b0; memAck = 1'b1; memData = 16'hA5A5; end
      tick();
    end
    memAck = 1'b0;
    checks++; if ({instrValid, fault, instruction, PC, pcNext} !== {2'b10, 16'hA5A5, 16'h0001, 16'h0002}) begin errors++; $display("FAIL delay_done: got %h expected %h", {instrValid, fault, instruction, PC, pcNext}, {2'b10, 16'hA5A5, 16'h0001, 16'h0002}); end
    tick();
    checks++; if ({instrValid, memReq} !== 2'b00) begin errors++; $display("FAIL delay_single: got %b expected 00", {instrValid, memReq}); end
  endtask

  task automatic test_redirect_in_wait();
    fetch = 1'b1; tick(); fetch = 1'b0;
    pcLoad = 1'b1; pcTarget = 16'h0030; tick();
    pcTarget = 16'h0040; tick();
    pcLoad = 1'b0; tick();
    checks++; if ({memReq, memAddr, pcNext} !== {1'b1, 16'h0002, 16'h0002}) begin errors++; $display("FAIL redir_pending: got %h expected %h", {memReq, memAddr, pcNext}, {1'b1, 16'h0002, 16'h0002}); end
    memAck = 1'b1; memData = 16'hBEEF; tick(); memAck = 1'b0;
    checks++; if ({instrValid, memReq, instruction, PC} !== {2'b00, 16'hA5A5, 16'h0001}) begin errors++; $display("FAIL redir_discard: got %h expected %h", {instrValid, memReq, instruction, PC}, {2'b00, 16'hA5A5, 16'h0001}); end
    checks++; if (pcNext !== 16'h0040) begin errors++; $display("FAIL redir_pcnext: got %h expected 0040", pcNext); end
    fetch = 1'b1; tick(); fetch = 1'b0;
    checks++; if (memAddr !== 16'h0040) begin errors++; $display("FAIL redir_addr: got %h expected 0040", memAddr); end
    memAck = 1'b1; memData = 16'h1111; tick(); memAck = 1'b0;
    checks++; if ({instrValid, PC, pcNext} !== {1'b1, 16'h0040, 16'h0041}) begin errors++; $display("FAIL redir_fetch: got %h expected %h", {instrValid, PC, pcNext}, {1'b1, 16'h0040, 16'h0041}); end
  endtask

  task automatic test_wrap();
    pcLoad = 1'b1; pcTarget = 16'hFFFF; tick(); pcLoad = 1'b0;
    checks++; if ({busy, pcNext} !== {1'b0, 16'hFFFF}) begin errors++; $display("FAIL wrap_load: got %h expected %h", {busy, pcNext}, {1'b0, 16'hFFFF}); end
    fetch = 1'b1; tick(); fetch = 1'b0;
    checks++; if (memAddr !== 16'hFFFF) begin errors++; $display("FAIL wrap_addr: got %h expected ffff", memAddr); end
    memAck = 1'b1; memData = 16'h7777; tick(); memAck = 1'b0;
    checks++; if ({instruction, PC, pcNext} !== {16'h7777, 16'hFFFF, 16'h0000}) begin errors++; $display("FAIL wrap_pc: got %h expected %h", {instruction, PC, pcNext}, {16'h7777, 16'hFFFF, 16'h0000}); end
  endtask

  task automatic test_fetch_and_load();
    fetch = 1'b1; pcLoad = 1'b1; pcTarget = 16'h0100; tick(); fetch = 1'b0; pcLoad = 1'b0;
    checks++; if ({memReq, memAddr, pcNext} !== {1'b1, 16'h0100, 16'h0100}) begin errors++; $display("FAIL both_addr: got %h expected %h", {memReq, memAddr, pcNext}, {1'b1, 16'h0100, 16'h0100}); end
    memAck = 1'b1; memData = 16'h3333; tick(); memAck = 1'b0;
    checks++; if ({instrValid, instruction, PC, pcNext} !== {1'b1, 16'h3333, 16'h0100, 16'h0101}) begin errors++; $display("FAIL both_done: got %h expected %h", {instrValid, instruction, PC, pcNext}, {1'b1, 16'h3333, 16'h0100, 16'h0101}); end
  endtask

  task automatic test_timeout();
    fetch = 1'b1; tick(); fetch = 1'b0;
    for (int i = 0; i < 14; i++) begin
      checks++; if ({busy, fault, memReq} !== 3'b101) begin errors++; $display("FAIL tmo_wait_%0d: got %b expected 101", i, {busy, fault, memReq}); end
      tick();
    end
    checks++; if ({busy, fault, memReq} !== 3'b101) begin errors++; $display("FAIL tmo_edge: got %b expected 101", {busy, fault, memReq}); end
    tick();
    checks++; if ({busy, fault, memReq, pcNext} !== {3'b010, 16'h0101}) begin errors++; $display("FAIL tmo_fault: got %h expected %h", {busy, fault, memReq, pcNext}, {3'b010, 16'h0101}); end
    memAck = 1'b1; memData = 16'h9999; fetch = 1'b1; tick(); memAck = 1'b0; fetch = 1'b0;
    checks++; if ({fault, instrValid, memReq, instruction} !== {3'b100, 16'h3333}) begin errors++; $display("FAIL tmo_ignore: got %h expected %h", {fault, instrValid, memReq, instruction}, {3'b100, 16'h3333}); end
    clearFault = 1'b1; tick(); clearFault = 1'b0;
    checks++; if ({fault, busy, pcNext} !== {2'b00, 16'h0101}) begin errors++; $display("FAIL tmo_clear: got %h expected %h", {fault, busy, pcNext}, {2'b00, 16'h0101}); end
    fetch = 1'b1; tick(); fetch = 1'b0;
    checks++; if ({memReq, memAddr} !== {1'b1, 16'h0101}) begin errors++; $display("FAIL tmo_retry: got %h expected %h", {memReq, memAddr}, {1'b1, 16'h0101}); end
    memAck = 1'b1; memData = 16'h2222; tick(); memAck = 1'b0;
    checks++; if ({instrValid, instruction, PC} !== {1'b1, 16'h2222, 16'h0101}) begin errors++; $display("FAIL tmo_retry_done: got %h expected %h", {instrValid, instruction, PC}, {1'b1, 16'h2222, 16'h0101}); end
  endtask

  task automatic test_reset_in_wait();
    fetch = 1'b1; tick(); fetch = 1'b0;
    tick(); tick();
    checks++; if ({busy, memReq, memAddr} !== {2'b11, 16'h0102}) begin errors++; $display("FAIL rstw_pre: got %h expected %h", {busy, memReq, memAddr}, {2'b11, 16'h0102}); end
    reset = 1'b0; tick(); reset = 1'b1;
    checks++; if ({memReq, busy, instrValid, pcNext} !== {3'b000, 16'h0000}) begin errors++; $display("FAIL rstw_abort: got %h expected %h", {memReq, busy, instrValid, pcNext}, {3'b000, 16'h0000}); end
    memAck = 1'b1; memData = 16'h5555; tick(); memAck = 1'b0;
    checks++; if ({instrValid, instruction, pcNext} !== {1'b0, 16'h0000, 16'h0000}) begin errors++; $display("FAIL rstw_late_ack: got %h expected %h", {instrValid, instruction, pcNext}, {1'b0, 16'h0000, 16'h0000}); end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_delayed_ack();
    test_redirect_in_wait();
    test_wrap();
    test_fetch_and_load();
    test_timeout();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Upstream fetch stage of the 16-bit multicycle datapath.
- Owns the program counter and issues instruction-memory reads using a req/ack handshake.
- Captures the returned word and presents `instruction` and `PC` to the decode/execute stage, which latches them on its IRWrite cycle.
- Supports PC redirect (branch/jump target) and flags memory timeouts.

Parameters:
- DATA_W, 16, instruction/address width.
- PC_RESET, 16'h0000, PC value after reset.
- PC_STEP, 1, PC increment per fetch (word-addressed).
- TIMEOUT, 15, maximum WAIT cycles without memAck before fault; range 1..255.

Ports:
- CLK, input, 1, single clock; all state updates on posedge.
- reset, input, 1, synchronous, active-low; sampled on posedge CLK.
- fetch, input, 1, request one instruction fetch (pulse or level; sampled in IDLE only).
- pcLoad, input, 1, redirect PC to pcTarget.
- pcTarget, input, DATA_W, redirect address.
- clearFault, input, 1, leave FAULT state.
- memAddr, output, DATA_W, instruction-memory address.
- memReq, output, 1, read request, held until ack.
- memAck, input, 1, memory has valid memData this cycle.
- memData, input, DATA_W, instruction word from memory.
- instruction, output, DATA_W, last successfully fetched word.
- PC, output, DATA_W, address of `instruction`.
- pcNext, output, DATA_W, internal PC register (next fetch address).
- instrValid, output, 1, one-cycle pulse when `instruction`/`PC` update.
- busy, output, 1, high in WAIT.
- fault, output, 1, high in FAULT.

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE, pcNext=PC_RESET.
  - instruction=0, PC=0, memAddr=0, memReq=0, instrValid=0, fault=0.
  - Watchdog=0, pendingRedirect cleared.
  - Reset during WAIT abandons the access; memReq is low the cycle after.
- States: IDLE, WAIT, FAULT. busy=(state==WAIT), fault=(state==FAULT). instrValid defaults to 0 every cycle.
- IDLE:
  - pcLoad=1, fetch=0: pcNext<=pcTarget; stay IDLE.
  - fetch=1, pcLoad=0: memAddr<=pcNext, memReq<=1, watchdog<=0, ->WAIT.
  - fetch=1, pcLoad=1: redirect wins the address. memAddr<=pcTarget, pcNext<=pcTarget, memReq<=1, ->WAIT.
  - memAck in IDLE is ignored.
- WAIT:
  - memReq and memAddr are held stable.
  - fetch is ignored.
  - watchdog increments each cycle without memAck.
- WAIT, memAck=1 with no pending redirect:
  - instruction<=memData, PC<=memAddr.
  - pcNext<=memAddr+PC_STEP, truncated to DATA_W, so 16'hFFFF+1 wraps to 16'h0000.
  - instrValid<=1 for exactly one cycle, memReq<=0, ->IDLE.
  - Latency is 1 cycle from the ack edge to instrValid; the minimum fetch is 2 cycles (fetch edge, then ack edge).
- WAIT, pcLoad=1 with no ack in the same cycle:
  - Latch pendingRedirect=1 and the target.
  - A later pcLoad overwrites the target (last wins).
- WAIT, memAck=1 with a redirect pending (or pcLoad=1 in the same cycle):
  - Discard memData; instruction, PC and instrValid are unchanged.
  - pcNext<=target, pendingRedirect cleared, memReq<=0, ->IDLE.
- WAIT, watchdog reaches TIMEOUT without ack: memReq<=0, ->FAULT.
  - pcNext is unchanged; the same address is retried after clear.
  - A pending redirect still applies to pcNext on entry to FAULT.
- FAULT:
  - fetch and memAck are ignored.
  - pcLoad updates pcNext.
  - clearFault=1 ->IDLE.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package cpu_pkg:
  - DATA_W.
  - Fetch state encoding: IDLE=2'd0, WAIT=2'd1, FAULT=2'd2.
  - PC_RESET default.
- One natural sub-module, fetch_watchdog:
  - Parameterised saturating counter.
  - Inputs: CLK, reset, clr, en.
  - Output: expired.
  - Instantiated once.

Test Plan:
- Reset, then fetch pulse; memAck one cycle later with memData=16'h1234 -> memAddr=0, instruction=16'h1234, PC=0, pcNext=1, instrValid high exactly 1 cycle.
- Ack delayed 5 cycles -> memReq and memAddr stable for all 5 cycles, busy=1, single instrValid, no fault.
- pcLoad pcTarget=16'h0040 during WAIT, then ack with 16'hBEEF -> instruction keeps its previous value, no instrValid, pcNext=16'h0040; next fetch gives memAddr=16'h0040.
- pcNext=16'hFFFF, fetch and ack -> PC=16'hFFFF, pcNext=16'h0000.
- No ack for TIMEOUT (15) cycles -> fault=1, memReq=0; late memAck ignored; clearFault, then fetch -> memAddr equals the same address.
- reset driven low in the middle of WAIT -> next posedge memReq=0, pcNext=PC_RESET, instrValid never asserted.
